// File: rtl/a2d_rr_mstr.sv
// SPI master for the 12-bit A2D: converts left load cell, right load cell and battery in
// round-robin order, one channel per request, using a command frame then a read frame.
module a2d_rr_mstr #(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_BATT  = 3'd5,
    parameter int unsigned GAP_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        StIdle,
        StFrm1,
        StGap,
        StFrm2,
        StUpd
    } state_e;

    localparam logic [9:0] FrmLast = 10'd519;
    localparam logic [9:0] GapLast = 10'(GAP_CLKS - 1);

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [1:0]  rr_q, rr_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        ss_n_q, sclk_q, cnv_q;
    logic [11:0] lft_q, rght_q, batt_q;

    logic        frame_d, frame_start, fall_d, rise_d, upd_d;
    logic [4:0]  phase_d;
    logic [2:0]  ch_sel;
    logic [15:0] cmd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 10'd1;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (nxt) state_d = StFrm1;
            end
            StFrm1: begin
                if (cnt_q == FrmLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StFrm2;
                    cnt_d   = '0;
                end
            end
            StFrm2: begin
                if (cnt_q == FrmLast) begin
                    state_d = StUpd;
                    cnt_d   = '0;
                end
            end
            StUpd: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // All SPI outputs are registered, so they are decoded from the next-state count.
    // Within a frame each 32-clk bit slot is: high 0..7, low 8..23, high 24..31.
    always_comb begin
        frame_d     = (state_d == StFrm1) || (state_d == StFrm2);
        frame_start = frame_d && (state_d != state_q);
        phase_d     = cnt_d[4:0];
        fall_d      = frame_d && (phase_d == 5'd8);
        rise_d      = frame_d && (phase_d == 5'd24);
        upd_d       = (state_d == StUpd);
    end

    always_comb begin
        case (rr_q)
            2'd1:    ch_sel = CH_RGHT;
            2'd2:    ch_sel = CH_BATT;
            default: ch_sel = CH_LFT;
        endcase
        cmd = {2'b00, ch_sel, 11'h000};
    end

    always_comb begin
        tx_d = tx_q;
        if (frame_start) begin
            tx_d = cmd;
        end else if (fall_d && (cnt_d != 10'd8)) begin
            tx_d = {tx_q[14:0], 1'b0};
        end

        rx_d = rx_q;
        if (rise_d) rx_d = {rx_q[14:0], MISO};

        rr_d = rr_q;
        if (upd_d) rr_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rr_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            cnv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ss_n_q  <= ~frame_d;
            sclk_q  <= ~(frame_d && (phase_d >= 5'd8) && (phase_d < 5'd24));
            cnv_q   <= upd_d;
        end
    end

    // Result registers load on entry to UPD so they are already valid while cnv_cmplt is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q  <= '0;
            rght_q <= '0;
            batt_q <= '0;
        end else if (upd_d) begin
            case (rr_q)
                2'd1:    rght_q <= rx_q[11:0];
                2'd2:    batt_q <= rx_q[11:0];
                default: lft_q  <= rx_q[11:0];
            endcase
        end
    end

    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cnv_q;
    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = tx_q[15];

endmodule

// File: tb/tb_a2d_rr_mstr.sv
// Directed bench for a2d_rr_mstr with a clock-sampled A2D slave model
// (lft=C00, rght=3A5, batt=FFF; frame-1 response is junk that must be discarded).
module tb_a2d_rr_mstr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, SS_n, SCLK, MOSI;

    int tests = 0;
    int fails = 0;

    a2d_rr_mstr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- A2D slave model ----------------
    logic        ss_p = 1'b1, sclk_p = 1'b1;
    logic [15:0] m_tx = '0, m_rx = '0, m_resp;
    int          m_falls = 0, m_rises = 0, m_low = 0, m_high = 0;
    bit          m_phase = 1'b0;
    logic [2:0]  m_ch = '0;
    bit          custom = 1'b0;
    logic [15:0] f_cmd [2];
    int          f_low [2];
    int          f_falls [2];
    int          f_rises [2];
    int          gap2 = 0, frames = 0, pulses = 0;

    function automatic logic [15:0] frame_resp(input bit ph, input logic [2:0] ch, input bit cust);
        if (!ph) return 16'hDEAD;
        if (cust) return 16'hF123;
        case (ch)
            3'd0:    return 16'h0C00;
            3'd4:    return 16'h03A5;
            3'd5:    return 16'h0FFF;
            default: return 16'h0000;
        endcase
    endfunction

    assign m_resp = frame_resp(m_phase, m_ch, custom);

    always @(posedge clk) begin
        if (cnv_cmplt) pulses <= pulses + 1;
        if (!rst_n) begin
            ss_p    <= 1'b1;
            sclk_p  <= 1'b1;
            m_phase <= 1'b0;
            MISO    <= 1'b0;
        end else begin
            ss_p   <= SS_n;
            sclk_p <= SCLK;
            if (ss_p && !SS_n) begin
                m_falls <= 0;
                m_rises <= 0;
                m_low   <= 1;
                if (m_phase) gap2 <= m_high;
                m_tx    <= m_resp;
                MISO    <= m_resp[15];
            end else if (!SS_n) begin
                m_low <= m_low + 1;
                if (sclk_p && !SCLK) begin
                    m_falls <= m_falls + 1;
                    if (m_falls > 0) begin
                        m_tx <= m_tx << 1;
                        MISO <= m_tx[14];
                    end
                end
                if (!sclk_p && SCLK) begin
                    m_rises <= m_rises + 1;
                    m_rx    <= {m_rx[14:0], MOSI};
                end
            end else if (!ss_p && SS_n) begin
                f_cmd[m_phase]   <= m_rx;
                f_low[m_phase]   <= m_low;
                f_falls[m_phase] <= m_falls;
                f_rises[m_phase] <= m_rises;
                frames           <= frames + 1;
                if (!m_phase) m_ch <= m_rx[13:11];
                m_phase <= ~m_phase;
                m_high  <= 1;
            end else begin
                m_high <= m_high + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the caller at the negedge of frame-1 cycle 0.
    task automatic start_conv();
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_cmplt(input int budget, output int n);
        n = 0;
        while (!cnv_cmplt && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cnv_cmplt !== 1'b1) begin
            fails++;
            $display("FAIL wait_cmplt: cnv_cmplt=%b after %0d clks, want 1", cnv_cmplt, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad_ss = 0, bad_sclk = 0, p0;
        do_reset();
        p0 = pulses;
        repeat (1000) begin
            @(negedge clk);
            if (SS_n !== 1'b1) bad_ss++;
            if (SCLK !== 1'b1) bad_sclk++;
        end
        tests++; if (bad_ss != 0) begin fails++; $display("FAIL rst_ss_n: %0d low clks, want 0", bad_ss); end
        tests++; if (bad_sclk != 0) begin fails++; $display("FAIL rst_sclk: %0d low clks, want 0", bad_sclk); end
        tests++; if (MOSI !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
        tests++; if (lft_ld !== 12'h000) begin fails++; $display("FAIL rst_lft: got %h want 000", lft_ld); end
        tests++; if (rght_ld !== 12'h000) begin fails++; $display("FAIL rst_rght: got %h want 000", rght_ld); end
        tests++; if (batt !== 12'h000) begin fails++; $display("FAIL rst_batt: got %h want 000", batt); end
        tests++; if (pulses - p0 != 0) begin fails++; $display("FAIL rst_cmplt: got %0d pulses want 0", pulses - p0); end
    endtask

    task automatic test_single();
        int n, p0, fr0;
        p0 = pulses;
        fr0 = frames;
        start_conv();
        wait_cmplt(1200, n);
        tests++; if (n != 1042) begin fails++; $display("FAIL single_latency: got %0d want 1042", n); end
        tests++; if (lft_ld !== 12'hC00) begin fails++; $display("FAIL single_lft: got %h want C00", lft_ld); end
        repeat (5) @(negedge clk);
        tests++; if (frames - fr0 != 2) begin fails++; $display("FAIL single_frames: got %0d want 2", frames - fr0); end
        tests++; if (f_cmd[0] !== 16'h0000) begin fails++; $display("FAIL single_cmd1: got %h want 0000", f_cmd[0]); end
        tests++; if (f_cmd[1] !== 16'h0000) begin fails++; $display("FAIL single_cmd2: got %h want 0000", f_cmd[1]); end
        tests++; if (f_low[0] != 520) begin fails++; $display("FAIL single_len1: got %0d want 520", f_low[0]); end
        tests++; if (f_low[1] != 520) begin fails++; $display("FAIL single_len2: got %0d want 520", f_low[1]); end
        tests++; if (gap2 != 2) begin fails++; $display("FAIL single_gap: got %0d want 2", gap2); end
        tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
        tests++; if (rght_ld !== 12'h000) begin fails++; $display("FAIL single_rght: got %h want 000", rght_ld); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_cmd [4];
        int n;
        exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            start_conv();
            wait_cmplt(1200, n);
            repeat (3) @(negedge clk);
            tests++;
            if (f_cmd[0] !== exp_cmd[i]) begin
                fails++; $display("FAIL rr_cmd1[%0d]: got %h want %h", i, f_cmd[0], exp_cmd[i]);
            end
            tests++;
            if (f_cmd[1] !== exp_cmd[i]) begin
                fails++; $display("FAIL rr_cmd2[%0d]: got %h want %h", i, f_cmd[1], exp_cmd[i]);
            end
        end
        tests++; if (lft_ld !== 12'hC00) begin fails++; $display("FAIL rr_lft: got %h want C00", lft_ld); end
        tests++; if (rght_ld !== 12'h3A5) begin fails++; $display("FAIL rr_rght: got %h want 3A5", rght_ld); end
        tests++; if (batt !== 12'hFFF) begin fails++; $display("FAIL rr_batt: got %h want FFF", batt); end
    endtask

    // rr is 1 on entry (four conversions after reset).
    task automatic test_ignore_nxt();
        int n, p0, fr0;
        p0 = pulses;
        fr0 = frames;
        start_conv();
        repeat (100) @(negedge clk);
        start_conv();
        repeat (419) @(negedge clk);
        tests++; if (SS_n !== 1'b1) begin fails++; $display("FAIL ign_in_gap: SS_n got %b want 1", SS_n); end
        start_conv();
        wait_cmplt(1200, n);
        tests++; if (n != 521) begin fails++; $display("FAIL ign_latency: got %0d want 521", n); end
        repeat (1200) @(negedge clk);
        tests++; if (frames - fr0 != 2) begin fails++; $display("FAIL ign_frames: got %0d want 2", frames - fr0); end
        tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL ign_pulses: got %0d want 1", pulses - p0); end
        tests++; if (f_cmd[0] !== 16'h2000) begin fails++; $display("FAIL ign_cmd: got %h want 2000", f_cmd[0]); end
        start_conv();
        wait_cmplt(1200, n);
        repeat (3) @(negedge clk);
        tests++; if (f_cmd[0] !== 16'h2800) begin fails++; $display("FAIL ign_next_cmd: got %h want 2800", f_cmd[0]); end
        tests++; if (batt !== 12'hFFF) begin fails++; $display("FAIL ign_batt: got %h want FFF", batt); end
    endtask

    task automatic test_reset_mid();
        int n;
        start_conv();
        repeat (822) @(negedge clk);
        tests++; if (SS_n !== 1'b0) begin fails++; $display("FAIL mid_pre_ss: got %b want 0", SS_n); end
        tests++; if (SCLK !== 1'b0) begin fails++; $display("FAIL mid_pre_sclk: got %b want 0", SCLK); end
        rst_n = 1'b0;
        #1;
        tests++; if (SS_n !== 1'b1) begin fails++; $display("FAIL mid_ss: got %b want 1", SS_n); end
        tests++; if (SCLK !== 1'b1) begin fails++; $display("FAIL mid_sclk: got %b want 1", SCLK); end
        tests++; if (MOSI !== 1'b0) begin fails++; $display("FAIL mid_mosi: got %b want 0", MOSI); end
        tests++; if (lft_ld !== 12'h000) begin fails++; $display("FAIL mid_lft: got %h want 000", lft_ld); end
        tests++; if (rght_ld !== 12'h000) begin fails++; $display("FAIL mid_rght: got %h want 000", rght_ld); end
        tests++; if (batt !== 12'h000) begin fails++; $display("FAIL mid_batt: got %h want 000", batt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_conv();
        wait_cmplt(1200, n);
        repeat (3) @(negedge clk);
        tests++; if (f_cmd[0] !== 16'h0000) begin fails++; $display("FAIL mid_cmd: got %h want 0000", f_cmd[0]); end
        tests++; if (lft_ld !== 12'hC00) begin fails++; $display("FAIL mid_lft_after: got %h want C00", lft_ld); end
    endtask

    // rr is 1 on entry, so the custom result lands in rght_ld.
    task automatic test_custom();
        int n;
        custom = 1'b1;
        start_conv();
        wait_cmplt(1200, n);
        repeat (3) @(negedge clk);
        custom = 1'b0;
        tests++; if (rght_ld !== 12'h123) begin fails++; $display("FAIL cust_rght: got %h want 123", rght_ld); end
        tests++; if (f_cmd[0] !== 16'h2000) begin fails++; $display("FAIL cust_cmd: got %h want 2000", f_cmd[0]); end
        for (int f = 0; f < 2; f++) begin
            tests++;
            if (f_falls[f] != 16) begin fails++; $display("FAIL cust_falls[%0d]: got %0d want 16", f, f_falls[f]); end
            tests++;
            if (f_rises[f] != 16) begin fails++; $display("FAIL cust_rises[%0d]: got %0d want 16", f, f_rises[f]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ignore_nxt();
        test_reset_mid();
        test_custom();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
